// File: rtl/sudoku_game_ctrl.sv
// rtl/sudoku_game_ctrl.sv - top-level game sequencer for the handwritten-sudoku board
//
// Purpose: captures a puzzle seed and steps the game through IDLE, GEN, PLAY,
// SOLVE and DONE. Along the way it sequences the solver through its load, entry
// and solve phases, validates user entries, counts rejected entries, counts
// play time and drives the VGA stage.
//
// Optional feature macro: SUDOKU_CTRL_TIMER_EN (enables the play_secs timer;
// when undefined play_secs is tied to 0).
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   btn_start/enter/solve        one-cycle button pulses (start > solve > enter)
//   in_row, in_col, in_data      user entry coordinates and digit
//   board_blank[80:0]            1 = user-writable cell, index row*9+col
//   lfsr_in                      free-running random value, captured as seed
//   solver_done                  solver finished auto-solve (level)
//   seed, seed_load              latched seed and its 1-cycle update pulse
//   slv_start/read/solve         1-cycle solver command pulses
//   slv_row/col/data             last accepted entry
//   stage                        0 IDLE, 1 GEN, 2 PLAY/SOLVE, 3 DONE
//   entry_err, err_cnt           reject pulse and saturating reject count
//   timeout                      SOLVE ended without solver_done
//   play_secs                    seconds spent in PLAY (saturating)
module sudoku_game_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int GEN_WAIT      = 16,
    parameter int SOLVE_TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_enter,
    input  logic        btn_solve,
    input  logic [3:0]  in_row,
    input  logic [3:0]  in_col,
    input  logic [3:0]  in_data,
    input  logic [80:0] board_blank,
    input  logic [15:0] lfsr_in,
    input  logic        solver_done,
    output logic [15:0] seed,
    output logic        seed_load,
    output logic        slv_start,
    output logic        slv_read,
    output logic        slv_solve,
    output logic [3:0]  slv_row,
    output logic [3:0]  slv_col,
    output logic [3:0]  slv_data,
    output logic [1:0]  stage,
    output logic        entry_err,
    output logic [7:0]  err_cnt,
    output logic        timeout,
    output logic [15:0] play_secs
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_SOLVE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int GW = $clog2(GEN_WAIT + 1);
    localparam int SW = $clog2(SOLVE_TIMEOUT + 1);

    logic [2:0]    state;
    logic [GW-1:0] gen_cnt;
    logic [SW-1:0] solve_cnt;

    logic          range_ok;
    logic [6:0]    cell_idx;
    logic          entry_ok;
    logic          do_restart;

    // The cell index is only formed once the coordinates are known to be in
    // range, so board_blank is never selected beyond bit 80.
    always_comb begin
        range_ok = (in_row <= 4'd8) && (in_col <= 4'd8) &&
                   (in_data >= 4'd1) && (in_data <= 4'd9);
        cell_idx = 7'd0;
        if (range_ok)
            cell_idx = 7'(in_row) * 7'd9 + 7'(in_col);
        entry_ok = range_ok && board_blank[cell_idx];
    end

    // GEN is the only state that ignores btn_start.
    assign do_restart = btn_start && (state != S_GEN);

    always_comb begin
        case (state)
            S_GEN:   stage = 2'd1;
            S_PLAY:  stage = 2'd2;
            S_SOLVE: stage = 2'd2;
            S_DONE:  stage = 2'd3;
            default: stage = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            gen_cnt   <= '0;
            solve_cnt <= '0;
            seed      <= 16'd0;
            seed_load <= 1'b0;
            slv_start <= 1'b0;
            slv_read  <= 1'b0;
            slv_solve <= 1'b0;
            slv_row   <= 4'd0;
            slv_col   <= 4'd0;
            slv_data  <= 4'd0;
            entry_err <= 1'b0;
            err_cnt   <= 8'd0;
            timeout   <= 1'b0;
        end else begin
            seed_load <= 1'b0;
            slv_start <= 1'b0;
            slv_read  <= 1'b0;
            slv_solve <= 1'b0;
            entry_err <= 1'b0;

            if (do_restart) begin
                state     <= S_GEN;
                gen_cnt   <= '0;
                seed      <= lfsr_in;
                seed_load <= 1'b1;
                err_cnt   <= 8'd0;
                timeout   <= 1'b0;
            end else begin
                case (state)
                    S_GEN: begin
                        if (gen_cnt == GW'(GEN_WAIT - 1)) begin
                            state     <= S_PLAY;
                            slv_start <= 1'b1;
                        end else begin
                            gen_cnt <= gen_cnt + 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (btn_solve) begin
                            state     <= S_SOLVE;
                            solve_cnt <= '0;
                            slv_solve <= 1'b1;
                        end else if (btn_enter) begin
                            if (entry_ok) begin
                                slv_row  <= in_row;
                                slv_col  <= in_col;
                                slv_data <= in_data;
                                slv_read <= 1'b1;
                            end else begin
                                entry_err <= 1'b1;
                                if (err_cnt != 8'hFF)
                                    err_cnt <= err_cnt + 8'd1;
                            end
                        end
                    end
                    S_SOLVE: begin
                        if (solver_done) begin
                            state <= S_DONE;
                        end else if (solve_cnt == SW'(SOLVE_TIMEOUT - 1)) begin
                            state   <= S_DONE;
                            timeout <= 1'b1;
                        end else begin
                            solve_cnt <= solve_cnt + 1'b1;
                        end
                    end
                    S_DONE:  state <= S_DONE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef SUDOKU_CTRL_TIMER_EN
    localparam int PW = $clog2(CLK_HZ + 1);

    logic [PW-1:0] presc;
    logic [15:0]   secs;

    // The prescaler advances only while in PLAY, so time spent in SOLVE or
    // DONE does not count towards play time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            secs  <= 16'd0;
        end else if (do_restart) begin
            presc <= '0;
            secs  <= 16'd0;
        end else if (state == S_PLAY) begin
            if (presc == PW'(CLK_HZ - 1)) begin
                presc <= '0;
                if (secs != 16'hFFFF)
                    secs <= secs + 16'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign play_secs = secs;
`else
    assign play_secs = 16'd0;
`endif

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// tb/tb_sudoku_game_ctrl.sv - directed self-checking bench for sudoku_game_ctrl
module tb_sudoku_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_start, btn_enter, btn_solve;
    logic [3:0]  in_row, in_col, in_data;
    logic [80:0] board_blank;
    logic [15:0] lfsr_in;
    logic        solver_done;
    logic [15:0] seed;
    logic        seed_load, slv_start, slv_read, slv_solve;
    logic [3:0]  slv_row, slv_col, slv_data;
    logic [1:0]  stage;
    logic        entry_err;
    logic [7:0]  err_cnt;
    logic        timeout;
    logic [15:0] play_secs;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    sudoku_game_ctrl #(.CLK_HZ(10), .GEN_WAIT(4), .SOLVE_TIMEOUT(50)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_start(btn_start), .btn_enter(btn_enter), .btn_solve(btn_solve),
        .in_row(in_row), .in_col(in_col), .in_data(in_data),
        .board_blank(board_blank), .lfsr_in(lfsr_in), .solver_done(solver_done),
        .seed(seed), .seed_load(seed_load),
        .slv_start(slv_start), .slv_read(slv_read), .slv_solve(slv_solve),
        .slv_row(slv_row), .slv_col(slv_col), .slv_data(slv_data),
        .stage(stage), .entry_err(entry_err), .err_cnt(err_cnt),
        .timeout(timeout), .play_secs(play_secs)
    );

    task automatic press_start(input logic [15:0] val);
        lfsr_in = val; btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
    endtask

    task automatic press_enter(input logic [3:0] r, input logic [3:0] c, input logic [3:0] d);
        in_row = r; in_col = c; in_data = d; btn_enter = 1'b1;
        @(negedge clk);
        btn_enter = 1'b0;
    endtask

    task automatic press_solve();
        btn_solve = 1'b1;
        @(negedge clk);
        btn_solve = 1'b0;
    endtask

    task automatic wait_play();
        int n;
        n = 0;
        while (stage !== 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (stage !== 2'd2) $display("FAIL wait_play: stage=%0d required 2", stage);
        else pass_cnt++;
    endtask

    task automatic new_game(input logic [15:0] val);
        press_start(val);
        wait_play();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({seed, seed_load, slv_start, slv_read, slv_solve, slv_row, slv_col, slv_data,
             stage, entry_err, err_cnt, timeout, play_secs} !== '0)
            $display("FAIL reset_outputs: stage=%0d seed=%h err_cnt=%0d required all 0", stage, seed, err_cnt);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start();
        press_start(16'hACE1);
        total++;
        if (seed_load !== 1'b1 || seed !== 16'hACE1 || stage !== 2'd1)
            $display("FAIL start_seed: seed_load=%b seed=%h stage=%0d required 1 ace1 1", seed_load, seed, stage);
        else pass_cnt++;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (stage !== 2'd1 || slv_start !== 1'b0 || seed_load !== 1'b0)
                $display("FAIL gen_hold%0d: stage=%0d slv_start=%b seed_load=%b required 1 0 0", i, stage, slv_start, seed_load);
            else pass_cnt++;
        end
        @(negedge clk);
        total++;
        if (stage !== 2'd2 || slv_start !== 1'b1)
            $display("FAIL play_entry: stage=%0d slv_start=%b required 2 1", stage, slv_start);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (slv_start !== 1'b0) $display("FAIL slv_start_pulse: slv_start=%b required 0", slv_start);
        else pass_cnt++;
    endtask

    task automatic test_entry_ok();
        press_enter(4'd3, 4'd4, 4'd7);
        total++;
        if (slv_read !== 1'b1 || slv_row !== 4'd3 || slv_col !== 4'd4 || slv_data !== 4'd7 ||
            entry_err !== 1'b0 || err_cnt !== 8'd0)
            $display("FAIL entry_ok: read=%b r=%0d c=%0d d=%0d err=%b cnt=%0d required 1 3 4 7 0 0",
                     slv_read, slv_row, slv_col, slv_data, entry_err, err_cnt);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (slv_read !== 1'b0) $display("FAIL slv_read_pulse: slv_read=%b required 0", slv_read);
        else pass_cnt++;
        press_enter(4'd8, 4'd8, 4'd9);
        total++;
        if (slv_read !== 1'b1 || slv_row !== 4'd8 || slv_col !== 4'd8 || slv_data !== 4'd9)
            $display("FAIL entry_corner: read=%b r=%0d c=%0d d=%0d required 1 8 8 9", slv_read, slv_row, slv_col, slv_data);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_entry_err();
        logic [3:0] rows[4] = '{4'd3, 4'd9, 4'd0, 4'd3};
        logic [3:0] cols[4] = '{4'd4, 4'd4, 4'd0, 4'd4};
        logic [3:0] dats[4] = '{4'd0, 4'd5, 4'd5, 4'd10};
        for (int i = 0; i < 4; i++) begin
            press_enter(rows[i], cols[i], dats[i]);
            total++;
            if (entry_err !== 1'b1 || slv_read !== 1'b0 || err_cnt !== 8'(i + 1))
                $display("FAIL entry_err%0d: err=%b read=%b cnt=%0d required 1 0 %0d", i, entry_err, slv_read, err_cnt, i + 1);
            else pass_cnt++;
            @(negedge clk);
            total++;
            if (entry_err !== 1'b0) $display("FAIL entry_err_pulse%0d: err=%b required 0", i, entry_err);
            else pass_cnt++;
        end
        total++;
        if (slv_row !== 4'd8 || slv_col !== 4'd8 || slv_data !== 4'd9)
            $display("FAIL slv_hold: r=%0d c=%0d d=%0d required 8 8 9", slv_row, slv_col, slv_data);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) begin
            press_enter(4'd0, 4'd0, 4'd1);
            @(negedge clk);
        end
        total++;
        if (err_cnt !== 8'd255) $display("FAIL err_saturate: err_cnt=%0d required 255", err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_solve_done();
        press_solve();
        total++;
        if (slv_solve !== 1'b1 || stage !== 2'd2)
            $display("FAIL solve_start: slv_solve=%b stage=%0d required 1 2", slv_solve, stage);
        else pass_cnt++;
        press_enter(4'd0, 4'd0, 4'd0);
        total++;
        if (entry_err !== 1'b0 || slv_solve !== 1'b0)
            $display("FAIL solve_enter_ignored: err=%b slv_solve=%b required 0 0", entry_err, slv_solve);
        else pass_cnt++;
        repeat (18) @(negedge clk);
        solver_done = 1'b1;
        @(negedge clk);
        solver_done = 1'b0;
        total++;
        if (stage !== 2'd3 || timeout !== 1'b0)
            $display("FAIL solve_done: stage=%0d timeout=%b required 3 0", stage, timeout);
        else pass_cnt++;
        press_solve();
        press_enter(4'd0, 4'd0, 4'd0);
        total++;
        if (stage !== 2'd3 || entry_err !== 1'b0 || slv_solve !== 1'b0 || err_cnt !== 8'd255)
            $display("FAIL done_hold: stage=%0d err=%b slv_solve=%b cnt=%0d required 3 0 0 255", stage, entry_err, slv_solve, err_cnt);
        else pass_cnt++;
    endtask

    task automatic test_solve_timeout();
        press_start(16'h1234);
        total++;
        if (err_cnt !== 8'd0 || seed !== 16'h1234 || stage !== 2'd1)
            $display("FAIL restart_from_done: cnt=%0d seed=%h stage=%0d required 0 1234 1", err_cnt, seed, stage);
        else pass_cnt++;
        wait_play();
        @(negedge clk);
        press_solve();
        repeat (49) @(negedge clk);
        total++;
        if (stage !== 2'd2 || timeout !== 1'b0)
            $display("FAIL timeout_early: stage=%0d timeout=%b required 2 0", stage, timeout);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (stage !== 2'd3 || timeout !== 1'b1)
            $display("FAIL timeout_hit: stage=%0d timeout=%b required 3 1", stage, timeout);
        else pass_cnt++;
        press_start(16'h0F0F);
        total++;
        if (timeout !== 1'b0 || stage !== 2'd1)
            $display("FAIL timeout_clear: timeout=%b stage=%0d required 0 1", timeout, stage);
        else pass_cnt++;
        wait_play();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        in_row = 4'd3; in_col = 4'd4; in_data = 4'd2;
        btn_enter = 1'b1;
        press_start(16'h5555);
        btn_enter = 1'b0;
        total++;
        if (stage !== 2'd1 || slv_read !== 1'b0 || entry_err !== 1'b0 || seed_load !== 1'b1 || seed !== 16'h5555)
            $display("FAIL start_enter: stage=%0d read=%b err=%b load=%b seed=%h required 1 0 0 1 5555",
                     stage, slv_read, entry_err, seed_load, seed);
        else pass_cnt++;
        wait_play();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_solve();
        press_enter(4'd9, 4'd9, 4'd9);
        press_solve();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (stage !== 2'd0 || seed !== 16'd0 || err_cnt !== 8'd0 || slv_row !== 4'd0 || slv_data !== 4'd0)
            $display("FAIL async_reset: stage=%0d seed=%h cnt=%0d row=%0d data=%0d required all 0", stage, seed, err_cnt, slv_row, slv_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timer();
        press_start(16'h0001);
        wait_play();
        repeat (35) @(negedge clk);
`ifdef SUDOKU_CTRL_TIMER_EN
        total++;
        if (play_secs !== 16'd3) $display("FAIL play_secs_count: play_secs=%0d required 3", play_secs);
        else pass_cnt++;
        solver_done = 1'b1;
        press_solve();
        @(negedge clk);
        solver_done = 1'b0;
        repeat (20) @(negedge clk);
        total++;
        if (stage !== 2'd3 || play_secs !== 16'd3)
            $display("FAIL play_secs_frozen: stage=%0d play_secs=%0d required 3 3", stage, play_secs);
        else pass_cnt++;
`else
        total++;
        if (play_secs !== 16'd0) $display("FAIL play_secs_off: play_secs=%0d required 0", play_secs);
        else pass_cnt++;
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        btn_start = 1'b0; btn_enter = 1'b0; btn_solve = 1'b0;
        in_row = 4'd0; in_col = 4'd0; in_data = 4'd0;
        board_blank = '0;
        board_blank[31] = 1'b1;
        board_blank[80] = 1'b1;
        lfsr_in = 16'd0;
        solver_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_start();
        test_entry_ok();
        test_entry_err();
        test_saturate();
        test_solve_done();
        test_solve_timeout();
        test_back_to_back();
        test_reset_mid_solve();
        test_timer();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
